// File: rtl/axi_interconnect_crossbar_mresp_route_pkg.sv
// Shared constants and helpers for the crossbar master-side stages.
// Channel widths match the slave-request arbiter feeding this stage.
package axi_interconnect_crossbar_mresp_route_pkg;

    localparam int XBAR_NUM_SLAVE       = 4;
    localparam int XBAR_WIDTH_ADDRINFO  = 64;
    localparam int XBAR_WIDTH_RESPINFO  = 48;
    localparam int XBAR_NUM_OUTSTANDING = 4;

    // Bits needed to hold value (minimum 1), so log2(n-1) sizes an index.
    function automatic int log2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((value >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_order_fifo.sv
// In-order tracking FIFO of slave indices, register based, show-ahead.
// Push and pop may coincide at any fill level, including full.
module axi_interconnect_crossbar_order_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data
);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/axi_interconnect_crossbar_mresp_route.sv
// Master-port stage: registers arbitrated requests toward the master,
// tracks issue order and routes master responses back to the slaves.
module axi_interconnect_crossbar_mresp_route
    import axi_interconnect_crossbar_mresp_route_pkg::*;
#(
    parameter int MODE_READ         = 1,
    parameter int NUM_SLAVE         = XBAR_NUM_SLAVE,
    parameter int WIDTH_ADDRINFO    = XBAR_WIDTH_ADDRINFO,
    parameter int WIDTH_RESPINFO    = XBAR_WIDTH_RESPINFO,
    parameter int NUM_OUTSTANDING   = XBAR_NUM_OUTSTANDING,
    parameter int WIDTH_OUTSTANDING = log2(NUM_OUTSTANDING - 1),
    parameter int WIDTH_SLAVE       = log2(NUM_SLAVE - 1)
) (
    input  logic                                clk_sys,
    input  logic                                rst_n,
    input  logic [WIDTH_ADDRINFO+WIDTH_SLAVE-1:0] addr_info,
    input  logic                                addr_valid,
    output logic                                addr_ready,
    output logic [WIDTH_ADDRINFO-1:0]           m_addr_info,
    output logic                                m_addr_valid,
    input  logic                                m_addr_ready,
    input  logic [WIDTH_RESPINFO-1:0]           m_resp_info,
    input  logic                                m_resp_valid,
    output logic                                m_resp_ready,
    output logic [NUM_SLAVE*WIDTH_RESPINFO-1:0] s_resp_info,
    output logic [NUM_SLAVE-1:0]                s_resp_valid,
    input  logic [NUM_SLAVE-1:0]                s_resp_ready,
    output logic [WIDTH_OUTSTANDING:0]          outstanding,
    output logic                                resp_orphan
);

    localparam int CNT_W = WIDTH_OUTSTANDING + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_OUTSTANDING);

    logic [WIDTH_ADDRINFO-1:0] m_addr_info_q;
    logic [WIDTH_ADDRINFO-1:0] m_addr_info_d;
    logic                      m_addr_valid_q;
    logic                      m_addr_valid_d;
    logic [CNT_W-1:0]          outstanding_q;
    logic [CNT_W-1:0]          outstanding_d;
    logic                      resp_orphan_q;
    logic                      resp_orphan_d;

    logic                      accept;
    logic                      complete;
    logic                      empty;
    logic                      last;
    logic                      sel_ready;
    logic [WIDTH_SLAVE-1:0]    head;

    axi_interconnect_crossbar_order_fifo #(
        .WIDTH (WIDTH_SLAVE),
        .DEPTH (NUM_OUTSTANDING),
        .PTR_W (WIDTH_OUTSTANDING)
    ) u_order_fifo (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (addr_info[WIDTH_SLAVE-1:0]),
        .pop       (complete),
        .head_data (head)
    );

    always_comb begin
        empty      = (outstanding_q == '0);
        addr_ready = (~m_addr_valid_q | m_addr_ready)
                   & (outstanding_q != CNT_FULL);
        accept     = addr_valid & addr_ready;

        sel_ready    = 1'b0;
        s_resp_valid = '0;
        for (int i = 0; i < NUM_SLAVE; i++) begin
            if (head == WIDTH_SLAVE'(i)) begin
                sel_ready       = s_resp_ready[i];
                s_resp_valid[i] = m_resp_valid & ~empty;
            end
        end
        m_resp_ready = ~empty & sel_ready;

        // B channel has no last flag: every handshake ends a transaction.
        last     = (MODE_READ == 0) | m_resp_info[WIDTH_RESPINFO-1];
        complete = m_resp_valid & m_resp_ready & last;
    end

    always_comb begin
        m_addr_info_d  = m_addr_info_q;
        m_addr_valid_d = m_addr_valid_q;
        outstanding_d  = outstanding_q;
        resp_orphan_d  = m_resp_valid & empty;

        if (accept) begin
            m_addr_info_d  = addr_info[WIDTH_SLAVE +: WIDTH_ADDRINFO];
            m_addr_valid_d = 1'b1;
        end else if (m_addr_ready) begin
            m_addr_valid_d = 1'b0;
        end

        unique case ({accept, complete})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            m_addr_info_q  <= '0;
            m_addr_valid_q <= 1'b0;
            outstanding_q  <= '0;
            resp_orphan_q  <= 1'b0;
        end else begin
            m_addr_info_q  <= m_addr_info_d;
            m_addr_valid_q <= m_addr_valid_d;
            outstanding_q  <= outstanding_d;
            resp_orphan_q  <= resp_orphan_d;
        end
    end

    assign m_addr_info  = m_addr_info_q;
    assign m_addr_valid = m_addr_valid_q;
    assign outstanding  = outstanding_q;
    assign resp_orphan  = resp_orphan_q;
    assign s_resp_info  = {NUM_SLAVE{m_resp_info}};

endmodule

// File: tb/tb_axi_interconnect_crossbar_mresp_route.sv
// Bench for the master response router: directed steps plus random
// traffic checked against a queue-based model of issue order.
module tb_axi_interconnect_crossbar_mresp_route;

    localparam int NS = 4;
    localparam int WA = 64;
    localparam int WR = 48;
    localparam int WS = 2;
    localparam int NO = 4;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;
    logic rst_n;

    logic [WA+WS-1:0] a_info;
    logic             a_valid;
    logic             a_ready;
    logic [WA-1:0]    m_ainfo;
    logic             m_avalid;
    logic             m_aready;
    logic [WR-1:0]    r_info;
    logic             r_valid;
    logic             r_ready;
    logic [NS*WR-1:0] s_info;
    logic [NS-1:0]    s_valid;
    logic [NS-1:0]    s_ready;
    logic [2:0]       outst;
    logic             orphan;

    logic [WA+WS-1:0] w_ainfo;
    logic             w_avalid_in;
    logic             w_aready_out;
    logic [WA-1:0]    w_m_ainfo;
    logic             w_m_avalid;
    logic             w_m_aready;
    logic [WR-1:0]    w_rinfo;
    logic             w_rvalid;
    logic             w_rready;
    logic [NS*WR-1:0] w_sinfo;
    logic [NS-1:0]    w_svalid;
    logic [NS-1:0]    w_sready;
    logic [2:0]       w_outst;
    logic             w_orphan;

    axi_interconnect_crossbar_mresp_route #(
        .MODE_READ(1), .NUM_SLAVE(NS), .WIDTH_ADDRINFO(WA),
        .WIDTH_RESPINFO(WR), .NUM_OUTSTANDING(NO)
    ) dut_r (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .addr_info(a_info), .addr_valid(a_valid), .addr_ready(a_ready),
        .m_addr_info(m_ainfo), .m_addr_valid(m_avalid),
        .m_addr_ready(m_aready),
        .m_resp_info(r_info), .m_resp_valid(r_valid),
        .m_resp_ready(r_ready),
        .s_resp_info(s_info), .s_resp_valid(s_valid),
        .s_resp_ready(s_ready),
        .outstanding(outst), .resp_orphan(orphan)
    );

    axi_interconnect_crossbar_mresp_route #(
        .MODE_READ(0), .NUM_SLAVE(NS), .WIDTH_ADDRINFO(WA),
        .WIDTH_RESPINFO(WR), .NUM_OUTSTANDING(NO)
    ) dut_w (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .addr_info(w_ainfo), .addr_valid(w_avalid_in),
        .addr_ready(w_aready_out),
        .m_addr_info(w_m_ainfo), .m_addr_valid(w_m_avalid),
        .m_addr_ready(w_m_aready),
        .m_resp_info(w_rinfo), .m_resp_valid(w_rvalid),
        .m_resp_ready(w_rready),
        .s_resp_info(w_sinfo), .s_resp_valid(w_svalid),
        .s_resp_ready(w_sready),
        .outstanding(w_outst), .resp_orphan(w_orphan)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: issue-order queue of slave indices plus the
    // registered address slot and orphan flag.
    int            mq[$];
    bit            m_mav;
    logic [WA-1:0] m_info;
    bit            m_orph;

    task automatic chk(input string tag, input logic [191:0] obs,
                       input logic [191:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit av, input logic [WA-1:0] pay,
                         input logic [WS-1:0] sidx, input bit mar,
                         input bit rv, input bit lst,
                         input logic [NS-1:0] sr);
        a_valid  = av;
        a_info   = {pay, sidx};
        m_aready = mar;
        r_valid  = rv;
        r_info   = {lst, 15'($urandom), 32'($urandom)};
        s_ready  = sr;
        #1;
    endtask

    task automatic tick();
        bit            empty;
        bit            exp_ar;
        bit            exp_mrr;
        bit            acc;
        bit            comp;
        int            head;
        logic [NS-1:0] exp_sv;
        empty   = (mq.size() == 0);
        head    = empty ? 0 : mq[0];
        exp_ar  = (!m_mav || m_aready) && (mq.size() != NO);
        exp_sv  = (r_valid && !empty) ? NS'(1 << head) : '0;
        exp_mrr = !empty && s_ready[head];
        chk("addr_ready", 192'(a_ready), 192'(exp_ar));
        chk("s_resp_valid", 192'(s_valid), 192'(exp_sv));
        chk("m_resp_ready", 192'(r_ready), 192'(exp_mrr));
        chk("m_addr_valid", 192'(m_avalid), 192'(m_mav));
        chk("m_addr_info", 192'(m_ainfo), 192'(m_info));
        chk("outstanding", 192'(outst), 192'(mq.size()));
        chk("resp_orphan", 192'(orphan), 192'(m_orph));
        chk("s_resp_info", 192'(s_info), 192'({NS{r_info}}));
        acc  = a_valid && exp_ar;
        comp = r_valid && exp_mrr && r_info[WR-1];
        @(posedge clk_sys);
        if (comp) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(int'(a_info[WS-1:0]));
            m_mav  = 1'b1;
            m_info = a_info[WS +: WA];
        end else if (m_aready) begin
            m_mav = 1'b0;
        end
        m_orph = r_valid && empty;
        #1;
    endtask

    initial begin
        logic [WS-1:0] sids [5];
        logic [NS-1:0] drain_sv [3];
        sids     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        drain_sv = '{4'b0100, 4'b1000, 4'b0001};

        rst_n = 1'b0;
        a_valid = 0; a_info = '0; m_aready = 0;
        r_valid = 0; r_info = '0; s_ready = '0;
        w_avalid_in = 0; w_ainfo = '0; w_m_aready = 0;
        w_rvalid = 0; w_rinfo = '0; w_sready = '0;
        m_mav = 0; m_info = '0; m_orph = 0;
        #3;
        chk("rst_outstanding", 192'(outst), 192'(0));
        chk("rst_m_addr_valid", 192'(m_avalid), 192'(0));
        chk("rst_m_resp_ready", 192'(r_ready), 192'(0));
        #5 rst_n = 1'b1;
        @(posedge clk_sys); #1;

        drive(0, '0, 0, 1, 0, 0, 4'hF);
        tick();

        // Single 4-beat read burst routed to slave 2.
        drive(1, 64'h1000, 2, 1, 0, 0, 4'hF);
        chk("single_mav_pre", 192'(m_avalid), 192'(0));
        tick();
        chk("single_mav_post", 192'(m_avalid), 192'(1));
        chk("single_info", 192'(m_ainfo), 192'(64'h1000));
        chk("single_out1", 192'(outst), 192'(1));
        for (int b = 0; b < 4; b++) begin
            drive(0, '0, 0, 1, 1, b == 3, 4'hF);
            chk("single_sv", 192'(s_valid), 192'(4'b0100));
            tick();
        end
        chk("single_out0", 192'(outst), 192'(0));

        // Saturation: four accepted, fifth waits for a completion.
        for (int k = 0; k < 4; k++) begin
            drive(1, 64'hA000 + 64'(k), sids[k], 1, 0, 0, 4'hF);
            tick();
        end
        drive(1, 64'hA004, sids[4], 1, 0, 0, 4'hF);
        chk("sat_ready_full", 192'(a_ready), 192'(0));
        chk("sat_out4", 192'(outst), 192'(4));
        tick();
        drive(1, 64'hA004, sids[4], 1, 1, 1, 4'hF);
        chk("sat_ready_cmpl", 192'(a_ready), 192'(0));
        tick();
        drive(1, 64'hA004, sids[4], 1, 0, 0, 4'hF);
        chk("sat_ready_after", 192'(a_ready), 192'(1));
        tick();
        chk("sat_out4_again", 192'(outst), 192'(4));
        chk("sat_info5", 192'(m_ainfo), 192'(64'hA004));
        for (int k = 0; k < 4; k++) begin
            drive(0, '0, 0, 1, 1, 1, 4'hF);
            tick();
        end
        chk("sat_drained", 192'(outst), 192'(0));

        // Ordering with backpressure from slave 3.
        drive(1, 64'h3000, 3, 1, 0, 0, 4'hF);
        tick();
        drive(1, 64'h3001, 1, 1, 0, 0, 4'hF);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(0, '0, 0, 1, 1, 1, 4'b0111);
            chk("bp_mrr_low", 192'(r_ready), 192'(0));
            chk("bp_sv_held", 192'(s_valid), 192'(4'b1000));
            tick();
        end
        drive(0, '0, 0, 1, 1, 1, 4'hF);
        chk("bp_mrr_high", 192'(r_ready), 192'(1));
        tick();
        drive(0, '0, 0, 1, 1, 1, 4'hF);
        chk("bp_next_sv", 192'(s_valid), 192'(4'b0010));
        tick();
        chk("bp_out0", 192'(outst), 192'(0));

        // Accept and complete together at three outstanding.
        for (int k = 1; k < 4; k++) begin
            drive(1, 64'h4000 + 64'(k), 2'(k), 1, 0, 0, 4'hF);
            tick();
        end
        chk("sim_out3_pre", 192'(outst), 192'(3));
        drive(1, 64'h4004, 0, 1, 1, 1, 4'hF);
        chk("sim_ready", 192'(a_ready), 192'(1));
        tick();
        chk("sim_out3_post", 192'(outst), 192'(3));
        for (int k = 0; k < 3; k++) begin
            drive(0, '0, 0, 1, 1, 1, 4'hF);
            chk("sim_order", 192'(s_valid), 192'(drain_sv[k]));
            tick();
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 3) != 0, {$urandom, $urandom}, 2'($urandom),
                  ($urandom % 4) != 0, 1'($urandom),
                  ($urandom % 3) == 0, 4'($urandom));
            tick();
        end
        for (int c = 0; c < 60 && mq.size() > 0; c++) begin
            drive(0, '0, 0, 1, 1, 1, 4'hF);
            tick();
        end
        chk("rand_drained", 192'(outst), 192'(0));

        // Write mode: every B beat completes.
        drive(0, '0, 0, 1, 0, 0, 4'hF);
        w_sready   = 4'hF;
        w_m_aready = 1'b1;
        w_avalid_in = 1'b1;
        w_ainfo    = {64'h5000, 2'd1};
        @(posedge clk_sys); #1;
        chk("wr_out1", 192'(w_outst), 192'(1));
        w_ainfo = {64'h5001, 2'd2};
        @(posedge clk_sys); #1;
        chk("wr_out2", 192'(w_outst), 192'(2));
        w_avalid_in = 1'b0;
        w_rvalid = 1'b1;
        w_rinfo  = 48'h0000_1234_5678;
        #1;
        chk("wr_sv1", 192'(w_svalid), 192'(4'b0010));
        chk("wr_mrr", 192'(w_rready), 192'(1));
        @(posedge clk_sys); #1;
        chk("wr_out1b", 192'(w_outst), 192'(1));
        chk("wr_sv2", 192'(w_svalid), 192'(4'b0100));
        @(posedge clk_sys); #1;
        chk("wr_out0", 192'(w_outst), 192'(0));
        w_rvalid = 1'b0;
        tick();

        // Reset mid-operation, then an orphan response.
        drive(1, 64'h6000, 0, 1, 0, 0, 4'hF);
        tick();
        drive(1, 64'h6001, 1, 1, 0, 0, 4'hF);
        tick();
        chk("rst_pre_out2", 192'(outst), 192'(2));
        drive(0, '0, 0, 0, 1, 0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mav", 192'(m_avalid), 192'(0));
        chk("rst_mid_info", 192'(m_ainfo), 192'(0));
        chk("rst_mid_out", 192'(outst), 192'(0));
        chk("rst_mid_orphan", 192'(orphan), 192'(0));
        chk("rst_mid_mrr", 192'(r_ready), 192'(0));
        chk("rst_mid_wout", 192'(w_outst), 192'(0));
        mq.delete();
        m_mav = 0; m_info = '0; m_orph = 0;
        #1 rst_n = 1'b1;
        tick();
        chk("orphan_pulse", 192'(orphan), 192'(1));
        chk("orphan_mrr", 192'(r_ready), 192'(0));
        drive(0, '0, 0, 1, 0, 0, 4'hF);
        tick();
        chk("orphan_clear", 192'(orphan), 192'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_interconnect_crossbar_mresp_route.md
Name: axi_interconnect_crossbar_mresp_route

Overview:
Per-master-port stage directly downstream of the slave-request arbiter. It consumes the arbitrated request `{payload, slave index}` and forwards the payload to the master-side AXI address channel through an output register. It records the slave index of every accepted request in an in-order tracking FIFO. It routes the master-side response channel (R or B) back to the originating slave port, and caps outstanding transactions at NUM_OUTSTANDING.

Parameters:
- MODE_READ, 1, 1 = R channel (multi-beat, last = resp_info MSB); 0 = B channel (every beat is last).
- NUM_SLAVE, 4, number of slave ports (1..4).
- WIDTH_ADDRINFO, 64, request payload width, excluding the slave index.
- WIDTH_RESPINFO, 48, response payload width; in read mode the MSB is the last flag.
- NUM_OUTSTANDING, 4, maximum accepted-but-unfinished transactions (power of two, ≥2).
- WIDTH_OUTSTANDING, LOG2(NUM_OUTSTANDING-1), FIFO pointer width.
- WIDTH_SLAVE, LOG2(NUM_SLAVE-1), slave index width.
- U_DLY, 1, register assignment delay.

Ports:
- clk_sys, in, 1, single clock; everything is on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- addr_info, in, WIDTH_ADDRINFO+WIDTH_SLAVE, request from the arbiter as `{payload, sidx}` (sidx in the LSBs).
- addr_valid, in, 1, request valid.
- addr_ready, out, 1, request accepted.
- m_addr_info, out, WIDTH_ADDRINFO, payload to the master port.
- m_addr_valid, out, 1, master address valid.
- m_addr_ready, in, 1, master address ready.
- m_resp_info, in, WIDTH_RESPINFO, response from the master port.
- m_resp_valid, in, 1, response valid.
- m_resp_ready, out, 1, response ready.
- s_resp_info, out, NUM_SLAVE*WIDTH_RESPINFO, response to the slave ports (broadcast to every lane).
- s_resp_valid, out, NUM_SLAVE, one-hot response valid.
- s_resp_ready, in, NUM_SLAVE, per-slave response ready.
- outstanding, out, WIDTH_OUTSTANDING+1, current outstanding count.
- resp_orphan, out, 1, one-cycle pulse: master response presented while the tracking FIFO is empty.

Behaviour:
- Reset (async, immediate): m_addr_valid=0, m_addr_info=0, outstanding=0, FIFO pointers=0, resp_orphan=0. Combinational outputs settle from the reset state.
- Reset mid-operation discards all tracking; responses arriving afterwards are treated as orphans.
- Accept condition: `addr_ready = (~m_addr_valid | m_addr_ready) & (outstanding != NUM_OUTSTANDING)`. This is combinational; no dependency on addr_valid.
- On addr_valid & addr_ready:
  - m_addr_info <= addr_info[WIDTH_SLAVE +: WIDTH_ADDRINFO]; m_addr_valid <= 1.
  - Push sidx (addr_info[WIDTH_SLAVE-1:0]) into the FIFO.
  - outstanding += 1.
  - Latency: one cycle from accept to m_addr_valid.
- On m_addr_ready & m_addr_valid with no new accept: m_addr_valid <= 0.
- m_addr_info holds its value while m_addr_valid & ~m_addr_ready (AXI stability rule).
- Back-to-back accepts sustain one request per cycle while m_addr_ready=1.
- Routing, with head = FIFO read data:
  - s_resp_valid = (m_resp_valid & ~empty) << head.
  - m_resp_ready = ~empty & s_resp_ready[head].
  - Every s_resp_info lane = m_resp_info; the path is combinational, zero latency.
- Completion = m_resp_valid & m_resp_ready & last.
  - last = m_resp_info[WIDTH_RESPINFO-1] when MODE_READ=1, else 1.
  - On completion: pop the FIFO and decrement outstanding.
  - Non-last beats do not pop; the burst stays routed to the same slave.
- Accept and completion in the same cycle: outstanding unchanged, push and pop both occur. This is legal at full count only if addr_ready was already high, so the count never exceeds NUM_OUTSTANDING.
- Full: outstanding == NUM_OUTSTANDING forces addr_ready=0. Once a completion occurs, addr_ready rises in the next cycle.
- Empty: m_resp_ready=0 and s_resp_valid=0. resp_orphan pulses (registered) in the cycle after m_resp_valid is seen with the FIFO empty; it pulses every such cycle.
- FIFO pointers wrap modulo NUM_OUTSTANDING; full/empty are derived from outstanding.
- Responses from the master side are in issue order (single ID per master port); reordering is out of scope.

Decomposition:
- Shared package/include: LOG2 function and the channel-width constants shared with the slave-request arbiter.
- One sub-module, axi_interconnect_crossbar_order_fifo:
  - Register-based FIFO, WIDTH_SLAVE wide, NUM_OUTSTANDING deep.
  - Show-ahead read data; push/pop/count interface.
  - Simultaneous push and pop allowed when full.
- Top level holds the address output register, outstanding counter, routing mux and orphan detector.

Test Plan:
- Single read (MODE_READ=1, NUM_SLAVE=4):
  - Stimulus: accept addr_info={0x1000, sidx=2}, then a 4-beat burst with last on beat 4, s_resp_ready=4'b1111.
  - Required: m_addr_valid one cycle after accept; s_resp_valid=4'b0100 for all 4 beats; outstanding 1→0 after beat 4.
- Saturation:
  - Stimulus: 5 back-to-back requests (sidx 0,1,2,3,0), m_addr_ready=1, no responses.
  - Required: 4 accepted; addr_ready=0 with outstanding=4; fifth accepted the cycle after the first completion.
- Ordering/backpressure:
  - Stimulus: issue sidx 3 then 1; s_resp_ready[3]=0 for 5 cycles.
  - Required: m_resp_ready=0 for those 5 cycles; s_resp_valid=4'b1000 held; after slave 3 completes, next response goes to 4'b0010.
- Simultaneous accept and complete at outstanding=3:
  - Required: outstanding stays 3; FIFO order preserved.
- Write mode (MODE_READ=0):
  - Stimulus: 2 B responses with resp_info MSB=0.
  - Required: each pops; outstanding 2→1→0.
- Orphan/reset:
  - Stimulus: m_resp_valid=1 with an empty FIFO.
  - Required: resp_orphan pulse, m_resp_ready=0.
  - Stimulus: assert rst_n=0 with outstanding=2.
  - Required: outputs return to reset values immediately.
